parity_frame_rx: RTL and testbench

- Serial receiver for the 4-bit even-parity frame produced by the team's XOR-chain parity generator plus its serializer.
- Frame on one wire: idle high, start bit (0), D0..D3 LSB first, parity bit, stop bit (1).
- Oversamples the line, recovers the nibble and checks parity and stop bit.
- Hands the result to the consumer through a valid/ready handshake, with overrun detection.

---
 rtl/parity_frame_rx.sv | 150 +++++++++++++++
 tb/tb_parity_frame_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Oversampling receiver for the 4-bit parity frame: start, D0..D3 (LSB first), parity, stop.
// Recovers the nibble, checks parity and stop bit, and holds the result behind a valid/ready handshake.
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shift_q;
    logic          par_q;
    logic          bit_end;
    logic          commit;
    logic          accept;

    assign rx_s    = sync_q[1];
    assign bit_end = (cnt == CNT_LAST);
    assign commit  = (state == ST_STOP) && bit_end;
    assign accept  = rx_valid && rx_ready;
    assign busy    = (state != ST_IDLE);

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= 2'd0;
            shift_q <= 4'd0;
            par_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= 2'd0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q[idx] <= rx_s;
                        cnt          <= '0;
                        idx          <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= ST_PARITY;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        par_q <= rx_s;
                        cnt   <= '0;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // A line stuck low must go high before another start is accepted.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Result register: a commit always wins over a simultaneous accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= 4'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            rx_data    <= shift_q;
            parity_err <= (^{shift_q, par_q}) ^ ODD_PARITY;
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
            overrun    <= rx_valid && !rx_ready;
        end else if (accept) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd parity instances share one line, checked every cycle
// against a frame-level model of the held result, plus directed busy/BREAK/glitch checks.
module tb_parity_frame_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;

    logic clk;
    logic rst;
    logic rx_in;
    logic rx_ready;

    logic [3:0] e_data, o_data;
    logic e_valid, e_perr, e_ferr, e_ovr, e_busy;
    logic o_valid, o_perr, o_ferr, o_ovr, o_busy;

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ready(rx_ready),
        .rx_data(e_data), .rx_valid(e_valid), .parity_err(e_perr),
        .frame_err(e_ferr), .overrun(e_ovr), .busy(e_busy)
    );

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ready(rx_ready),
        .rx_data(o_data), .rx_valid(o_valid), .parity_err(o_perr),
        .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the held result; a pending commit lands on the edge after the frame's last bit.
    logic       exp_valid, exp_perr_e, exp_perr_o, exp_ferr, exp_ovr;
    logic [3:0] exp_data;
    logic       pend;
    logic [3:0] pend_data;
    logic       pend_p, pend_stop;
    logic       rand_rdy;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic rdy, r;
        if (rand_rdy) rx_ready = ($urandom_range(0, 2) == 0);
        rdy = rx_ready;
        r   = rst;
        @(posedge clk);
        if (r) begin
            {exp_valid, exp_perr_e, exp_perr_o, exp_ferr, exp_ovr} = '0;
            exp_data = 4'd0;
            pend     = 1'b0;
        end else if (pend) begin
            exp_ovr    = exp_valid && !rdy;
            exp_valid  = 1'b1;
            exp_data   = pend_data;
            exp_perr_e = ^{pend_data, pend_p};
            exp_perr_o = ~(^{pend_data, pend_p});
            exp_ferr   = ~pend_stop;
            pend       = 1'b0;
        end else if (exp_valid && rdy) begin
            {exp_valid, exp_perr_e, exp_perr_o, exp_ferr, exp_ovr} = '0;
        end
        #1;
        check("even_out", {e_data, e_valid, e_perr, e_ferr, e_ovr},
              {exp_data, exp_valid, exp_perr_e, exp_ferr, exp_ovr});
        check("odd_out", {o_data, o_valid, o_perr, o_ferr, o_ovr},
              {exp_data, exp_valid, exp_perr_o, exp_ferr, exp_ovr});
    endtask

    // Drives the first nbits of the frame; a full frame schedules its commit.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop, input int nbits);
        logic [6:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = bits[i];
            repeat (CPB) step();
        end
        if (nbits == 7) begin
            pend      = 1'b1;
            pend_data = d;
            pend_p    = p;
            pend_stop = stop;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int busy_cnt;
        logic [3:0] d;
        logic p, stop;
        int gap;

        rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0; rand_rdy = 1'b0; pend = 1'b0;
        repeat (3) step();
        check("reset_busy", {6'd0, e_busy, o_busy}, 8'd0);
        rst = 1'b0;
        idle(4);

        // Nibble B, correct even parity; then one-cycle accept.
        send_frame(4'hB, 1'b1, 1'b1, 7);
        idle(3);
        rx_ready = 1'b1; step();
        rx_ready = 1'b0; step();
        idle(3);

        // Nibble B with P=0: even flags an error, odd does not.
        send_frame(4'hB, 1'b0, 1'b1, 7);
        idle(3);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        idle(3);

        // Stop bit 0 and the line held low: stays in BREAK, no second frame.
        send_frame(4'h6, 1'b0, 1'b0, 7);
        rx_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("break_busy", {6'd0, e_busy, o_busy}, 8'b11);
        end
        idle(4);
        check("break_release", {6'd0, e_busy, o_busy}, 8'd0);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        idle(3);

        // One-cycle low glitch: busy briefly, no frame.
        rx_in = 1'b0; step();
        rx_in = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (e_busy) busy_cnt++;
        end
        check("glitch_busy", {7'd0, (busy_cnt >= 1 && busy_cnt <= HALF + 1)}, 8'd1);
        check("glitch_idle", {6'd0, e_busy, o_busy}, 8'd0);

        // Back-to-back 3 then C, never accepted: overrun.
        send_frame(4'h3, 1'b0, 1'b1, 7);
        send_frame(4'hC, 1'b0, 1'b1, 7);
        idle(3);
        check("b2b_overrun", {3'd0, e_data, e_ovr}, {3'd0, 4'hC, 1'b1});
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        idle(2);

        // Back-to-back with accept on the second commit edge: no overrun.
        send_frame(4'h3, 1'b0, 1'b1, 7);
        send_frame(4'hC, 1'b0, 1'b1, 7);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        idle(2);
        check("b2b_accept", {2'd0, e_data, e_valid, e_ovr}, {2'd0, 4'hC, 1'b1, 1'b0});

        // Reset in the middle of DATA, then a clean frame.
        send_frame(4'h5, 1'b0, 1'b1, 3);
        rx_in = 1'b1;
        rst = 1'b1; step(); rst = 1'b0;
        check("midframe_reset", {6'd0, e_busy, o_busy}, 8'd0);
        idle(4);
        send_frame(4'h9, 1'b0, 1'b1, 7);
        idle(3);
        check("post_reset", {3'd0, e_data, e_valid}, {3'd0, 4'h9, 1'b1});

        // Random frames with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d    = 4'($urandom_range(0, 15));
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? $urandom_range(0, 3) : $urandom_range(2, 4);
            send_frame(d, p, stop, 7);
            idle(gap);
        end
        rand_rdy = 1'b0;
        rx_ready = 1'b0;
        idle(8);
        check("final_idle", {6'd0, e_busy, o_busy}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
